// File: rtl/a2d_rr_intf.sv
// Round-robin SPI master for a 12-bit ADC128S-style converter.
// One strt_cnv runs a six-transaction sweep (ch0, ch0, ch4, ch4, ch5, ch5).
// The first transaction of each pair selects the channel. The second one
// returns that channel's conversion, which is captured into its result register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | SS_n high, waiting for strt_cnv
// XFER  | SS_n low, 16-bit transaction in progress
// GAP   | SS_n high between transactions; after the 6th, signals completion
module a2d_rr_intf #(
    parameter int SCLK_DIV = 32,
    parameter int GAP      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    output logic        busy,
    output logic        cnv_cmplt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(3 * SCLK_DIV / 4 - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(SCLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LD   = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP_ST} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic          miso_q, miso_d;
    logic [2:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ss_n_q, ss_n_d;
    logic          busy_q, busy_d;
    logic          cmplt_q, cmplt_d;
    logic [11:0]   lft_q, lft_d;
    logic [11:0]   rght_q, rght_d;
    logic [11:0]   batt_q, batt_d;

    logic          sclk_rise;
    logic          sclk_fall;
    logic [15:0]   shift_nxt;

    // Command word for a transaction index: pairs map to channels 0, 4, 5.
    function automatic logic [15:0] cmd_for(input logic [2:0] idx);
        logic [2:0] ch;
        ch = 3'd5;
        if (idx < 3'd2)      ch = 3'd0;
        else if (idx < 3'd4) ch = 3'd4;
        return {2'b00, ch, 11'h000};
    endfunction

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            miso_q    <= 1'b0;
            idx_q     <= '0;
            gap_q     <= '0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            cmplt_q   <= 1'b0;
            lft_q     <= '0;
            rght_q    <= '0;
            batt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            miso_q    <= miso_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            cmplt_q   <= cmplt_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            batt_q    <= batt_d;
        end
    end

    assign sclk_rise = (cnt_q == CNT_RISE);
    assign sclk_fall = (cnt_q == CNT_TOP);
    assign shift_nxt = {shift_q[14:0], miso_q};

    // Next-state logic: sequencing, SCLK generation, shifting and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        cmplt_d   = 1'b0;
        lft_d     = lft_q;
        rght_d    = rght_q;
        batt_d    = batt_q;
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d   = XFER;
                    idx_d     = 3'd0;
                    busy_d    = 1'b1;
                    ss_n_d    = 1'b0;
                    cnt_d     = CNT_PRE;
                    bit_cnt_d = 5'd0;
                    shift_d   = cmd_for(3'd0);
                end
            end
            XFER: begin
                cnt_d = cnt_q + CW'(1);
                if (sclk_rise) begin
                    miso_d    = MISO;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                // The fall before the first rise carries no data, so it does not shift.
                if (sclk_fall && bit_cnt_q != 5'd0) begin
                    shift_d = shift_nxt;
                end
                // The wrap after the 16th rise ends the transaction instead of falling.
                if (sclk_fall && bit_cnt_q == 5'd16) begin
                    ss_n_d  = 1'b1;
                    state_d = GAP_ST;
                    gap_d   = GAP_LD;
                    case (idx_q)
                        3'd1:    lft_d  = shift_nxt[11:0];
                        3'd3:    rght_d = shift_nxt[11:0];
                        3'd5:    batt_d = shift_nxt[11:0];
                        default: ;
                    endcase
                end
            end
            GAP_ST: begin
                if (idx_q == 3'd5) begin
                    // Completion cycle is spent in GAP so a coincident strt_cnv is dropped.
                    if (!cmplt_q) begin
                        cmplt_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (gap_q == '0) begin
                    state_d   = XFER;
                    idx_d     = idx_q + 3'd1;
                    ss_n_d    = 1'b0;
                    cnt_d     = CNT_PRE;
                    bit_cnt_d = 5'd0;
                    shift_d   = cmd_for(idx_q + 3'd1);
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = ss_n_q | cnt_q[CW-1];
    assign MOSI      = ~ss_n_q & shift_q[15];
    assign busy      = busy_q;
    assign cnv_cmplt = cmplt_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Bench for a2d_rr_intf: behavioural SPI slave, sweep-level result model.
module tb_a2d_rr_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic        MISO;
    logic        busy, cnv_cmplt, SS_n, SCLK, MOSI;
    logic [11:0] lft_ld, rght_ld, batt;

    a2d_rr_intf dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .busy(busy),
        .cnv_cmplt(cnv_cmplt), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Slave bookkeeping
    logic [15:0] sdata [6];
    logic [15:0] mosi_w [8];
    int          rises [8];
    int          lowlen [8];
    logic [15:0] shreg = 16'h0;
    logic [15:0] rxw = 16'h0;
    logic        ss_p = 1'b1, sc_p = 1'b1;
    int          txn_cnt = 0, rcnt = 0, fall_cyc = 0;
    int          sclk_edges = 0, ss_falls = 0, cmplt_cnt = 0;
    logic [11:0] exp_l = 12'h0, exp_r = 12'h0, exp_b = 12'h0;

    assign MISO = shreg[15];

    // Mode-3 style slave: samples MOSI on SCLK rise, shifts MISO on falls after a rise.
    always @(SS_n or SCLK) begin
        if (ss_p === 1'b1 && SS_n === 1'b0) begin
            ss_falls++;
            shreg    = (txn_cnt < 6) ? sdata[txn_cnt] : 16'h0;
            rcnt     = 0;
            rxw      = 16'h0;
            fall_cyc = cyc;
        end else if (ss_p === 1'b0 && SS_n === 1'b1) begin
            if (txn_cnt < 8) begin
                mosi_w[txn_cnt] = rxw;
                rises[txn_cnt]  = rcnt;
                lowlen[txn_cnt] = cyc - fall_cyc;
            end
            txn_cnt++;
        end else if (SS_n === 1'b0) begin
            if (sc_p === 1'b0 && SCLK === 1'b1) begin
                rxw = {rxw[14:0], MOSI};
                rcnt++;
            end else if (sc_p === 1'b1 && SCLK === 1'b0 && rcnt > 0) begin
                shreg = {shreg[14:0], 1'b0};
            end
        end
        if (sc_p !== SCLK) sclk_edges++;
        ss_p = SS_n;
        sc_p = SCLK;
    end

    always @(negedge clk) if (cnv_cmplt === 1'b1) cmplt_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 6; k++) begin
            sdata[k] = 16'($urandom);
            if (k % 2 == 1) sdata[k][0] = 1'b1;
        end
    endtask

    // One full sweep; poke=1 also fires strt_cnv during txn 3 and in the cnv_cmplt cycle.
    task automatic do_sweep(input bit poke);
        int t0, lat, base, bad_busy, bad_res, ch;
        bit seen, poked;
        logic [11:0] nl, nr, nb;
        seen = 0; poked = 0; bad_busy = 0; bad_res = 0;
        nl = sdata[1][11:0];
        nr = sdata[3][11:0];
        nb = sdata[5][11:0];
        base = cmplt_cnt;
        txn_cnt = 0;
        @(negedge clk); strt_cnv = 1'b1; t0 = cyc;
        @(negedge clk); strt_cnv = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (cnv_cmplt === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if (lft_ld  !== ((txn_cnt >= 2) ? nl : exp_l) ||
                rght_ld !== ((txn_cnt >= 4) ? nr : exp_r) ||
                batt    !== ((txn_cnt >= 6) ? nb : exp_b)) bad_res++;
            if (poke && !poked && txn_cnt == 2 && SS_n === 1'b0) begin
                strt_cnv = 1'b1;
                poked = 1;
            end else begin
                strt_cnv = 1'b0;
            end
            @(negedge clk);
        end
        lat = cyc - t0;
        chk("cmplt_seen", 32'(seen), 32'd1);
        chk("latency", lat, 32'd3148);
        chk("busy_at_cmplt", 32'(busy), 32'd0);
        chk("busy_during", bad_busy, 32'd0);
        chk("result_hold", bad_res, 32'd0);
        exp_l = nl; exp_r = nr; exp_b = nb;
        chk("lft_ld", 32'(lft_ld), 32'(exp_l));
        chk("rght_ld", 32'(rght_ld), 32'(exp_r));
        chk("batt", 32'(batt), 32'(exp_b));
        if (poke) strt_cnv = 1'b1;
        @(negedge clk); strt_cnv = 1'b0;
        chk("cmplt_one_clk", 32'(cnv_cmplt), 32'd0);
        repeat (600) @(negedge clk);
        chk("txn_count", txn_cnt, 32'd6);
        chk("idle_after", 32'(busy), 32'd0);
        chk("cmplt_pulses", cmplt_cnt - base, 32'd1);
        for (int k = 0; k < 6; k++) begin
            ch = (k < 2) ? 0 : ((k < 4) ? 4 : 5);
            chk($sformatf("mosi_w%0d", k), 32'(mosi_w[k]), 32'(ch * 2048));
            chk($sformatf("rises%0d", k), rises[k], 32'd16);
            chk($sformatf("ss_low%0d", k), lowlen[k], 32'd521);
        end
    endtask

    initial begin
        int e0, f0, base;
        bit found;
        for (int k = 0; k < 6; k++) sdata[k] = 16'h0;

        // Reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_results", 32'({lft_ld, rght_ld, batt}), 32'd0);
        e0 = sclk_edges; f0 = ss_falls;
        repeat (1000) @(negedge clk);
        chk("idle_sclk_edges", sclk_edges - e0, 32'd0);
        chk("idle_ss_falls", ss_falls - f0, 32'd0);

        // Sweep 1: fixed pattern
        for (int k = 0; k < 6; k++) begin
            sdata[k] = (k % 2 == 0) ? 16'hF123 : 16'(16'hAC00 | ((k < 2) ? 0 : ((k < 4) ? 4 : 5)));
        end
        do_sweep(0);

        // Sweep 2: new data, results must hold until their own capture
        sdata[0] = 16'($urandom); sdata[1] = 16'h0BD0;
        sdata[2] = 16'($urandom); sdata[3] = 16'h0BC4;
        sdata[4] = 16'($urandom); sdata[5] = 16'h0BB5;
        do_sweep(0);

        // Sweep 3: random data, ignored strt_cnv pulses
        fill_random();
        do_sweep(1);

        // Mid-sweep reset during transaction 2
        fill_random();
        base = cmplt_cnt;
        txn_cnt = 0;
        found = 0;
        @(negedge clk); strt_cnv = 1'b1;
        @(negedge clk); strt_cnv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (txn_cnt == 1 && SS_n === 1'b0 && SCLK === 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_window_found", 32'(found), 32'd1);
        repeat (3) @(negedge clk);
        chk("sclk_low_before_rst", 32'(SCLK), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
        chk("mid_rst_sclk", 32'(SCLK), 32'd1);
        chk("mid_rst_mosi", 32'(MOSI), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_lft", 32'(lft_ld), 32'd0);
        chk("mid_rst_rght", 32'(rght_ld), 32'd0);
        chk("mid_rst_batt", 32'(batt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_l = 12'h0; exp_r = 12'h0; exp_b = 12'h0;
        repeat (1000) @(negedge clk);
        chk("no_cmplt_after_rst", cmplt_cnt - base, 32'd0);

        // Fresh sweeps after the abort
        fill_random();
        do_sweep(0);
        fill_random();
        do_sweep(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
